// File: rtl/fft_pkg.sv
// Shared FFT definitions used by the FFT core, the frame packer and the analysis stage.
//   FFT_N / FFT_LOG2N : frame size in bins and its log2
//   FFT_DATA_W        : default bin word width
//   fft_state_e       : frame packer states
//   bitrev4()         : 4-bit index bit reversal (radix-2 output order of a 16-point FFT)
package fft_pkg;

  localparam int unsigned FFT_N      = 16;
  localparam int unsigned FFT_LOG2N  = 4;
  localparam int unsigned FFT_DATA_W = 32;

  typedef enum logic {
    IDLE,
    FILL
  } fft_state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_frame_pack.sv
// Serial-to-parallel FFT frame packer.
// Collects one bin per valid beat (sop marks serial bin 0), optionally un-scrambles
// bit-reversed order, and presents each completed 16-bin frame in parallel.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid            : qualifies in_sop / in_data; no backpressure
//   in_sop              : marks serial bin index 0
//   in_data             : bin value
//   fft_d0 .. fft_d15   : registered frame slots, held between frames
//   fft_valid           : one-cycle pulse when a new frame is presented
//   frame_err           : one-cycle pulse after an orphan beat or an early sop
//   frame_cnt           : completed frame count, wraps
module fft_frame_pack
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W  = FFT_DATA_W,
  parameter bit          BIT_REV = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] fft_d0,
  output logic [DATA_W-1:0] fft_d1,
  output logic [DATA_W-1:0] fft_d2,
  output logic [DATA_W-1:0] fft_d3,
  output logic [DATA_W-1:0] fft_d4,
  output logic [DATA_W-1:0] fft_d5,
  output logic [DATA_W-1:0] fft_d6,
  output logic [DATA_W-1:0] fft_d7,
  output logic [DATA_W-1:0] fft_d8,
  output logic [DATA_W-1:0] fft_d9,
  output logic [DATA_W-1:0] fft_d10,
  output logic [DATA_W-1:0] fft_d11,
  output logic [DATA_W-1:0] fft_d12,
  output logic [DATA_W-1:0] fft_d13,
  output logic [DATA_W-1:0] fft_d14,
  output logic [DATA_W-1:0] fft_d15,
  output logic              fft_valid,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam logic [FFT_LOG2N-1:0] LastIdx = FFT_LOG2N'(FFT_N - 1);

  fft_state_e           state_q;
  logic [FFT_LOG2N-1:0] idx_q;
  logic                 fft_valid_q;
  logic                 frame_err_q;
  logic [15:0]          frame_cnt_q;

  logic [FFT_LOG2N-1:0] wr_idx;
  logic [FFT_LOG2N-1:0] wr_slot;
  logic                 wr_en;
  logic                 frame_done;

  // An sop beat always restarts at serial index 0, whatever state we are in.
  always_comb begin
    wr_idx     = (state_q == IDLE || in_sop) ? '0 : idx_q;
    wr_slot    = BIT_REV ? bitrev4(wr_idx) : wr_idx;
    wr_en      = in_valid && (in_sop || state_q == FILL);
    frame_done = in_valid && !in_sop && (state_q == FILL) && (idx_q == LastIdx);
  end

  // Frame state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fft_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      fft_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          IDLE: begin
            if (in_sop) begin
              idx_q   <= FFT_LOG2N'(1);
              state_q <= FILL;
            end else begin
              // Orphan beat: dropped.
              frame_err_q <= 1'b1;
            end
          end
          FILL: begin
            if (in_sop) begin
              // Early sop: partial frame abandoned, this beat is bin 0 of the next one.
              frame_err_q <= 1'b1;
              idx_q       <= FFT_LOG2N'(1);
            end else if (idx_q == LastIdx) begin
              fft_valid_q <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              idx_q       <= '0;
              state_q     <= IDLE;
            end else begin
              idx_q <= idx_q + FFT_LOG2N'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            idx_q   <= '0;
          end
        endcase
      end
    end
  end

  // Per-slot capture buffer and output register.
  for (genvar i = 0; i < FFT_N; i++) begin : g_slot
    logic [DATA_W-1:0] cap_q;
    logic [DATA_W-1:0] dout_q;

    // Capture contents are don't-care after reset; only the outputs are cleared.
    always_ff @(posedge clk) begin
      if (!rst && wr_en && wr_slot == FFT_LOG2N'(i)) begin
        cap_q <= in_data;
      end
    end

    // The final bin bypasses the buffer so the frame is presented on its own edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (frame_done) begin
        dout_q <= (wr_slot == FFT_LOG2N'(i)) ? in_data : cap_q;
      end
    end
  end

  assign fft_d0    = g_slot[0].dout_q;
  assign fft_d1    = g_slot[1].dout_q;
  assign fft_d2    = g_slot[2].dout_q;
  assign fft_d3    = g_slot[3].dout_q;
  assign fft_d4    = g_slot[4].dout_q;
  assign fft_d5    = g_slot[5].dout_q;
  assign fft_d6    = g_slot[6].dout_q;
  assign fft_d7    = g_slot[7].dout_q;
  assign fft_d8    = g_slot[8].dout_q;
  assign fft_d9    = g_slot[9].dout_q;
  assign fft_d10   = g_slot[10].dout_q;
  assign fft_d11   = g_slot[11].dout_q;
  assign fft_d12   = g_slot[12].dout_q;
  assign fft_d13   = g_slot[13].dout_q;
  assign fft_d14   = g_slot[14].dout_q;
  assign fft_d15   = g_slot[15].dout_q;
  assign fft_valid = fft_valid_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_pack.sv
module tb_fft_frame_pack;

  typedef logic [16*32-1:0] frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_sop;
  logic [31:0] in_data;

  // Instance A: natural order. Instance B: bit-reversed order. Same stimulus.
  logic [31:0] a_d [16];
  logic [31:0] b_d [16];
  logic        a_valid, b_valid, a_err, b_err;
  logic [15:0] a_cnt, b_cnt;
  frame_t      a_flat, b_flat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_edge = 1'b1;

  frame_t      a_q[$];
  frame_t      b_q[$];
  logic [15:0] a_cnt_q[$];
  logic [15:0] b_cnt_q[$];
  logic [15:0] exp_cnt = 16'd0;

  int     err_seen [2] = '{0, 0};
  int     vcyc     [2] = '{0, 0};
  int     vprev    [2] = '{0, 0};
  logic   vlast    [2] = '{1'b0, 1'b0};
  frame_t prev     [2] = '{'0, '0};

  always #5 clk = ~clk;

  fft_frame_pack #(.DATA_W(32), .BIT_REV(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .fft_d0(a_d[0]), .fft_d1(a_d[1]), .fft_d2(a_d[2]), .fft_d3(a_d[3]),
    .fft_d4(a_d[4]), .fft_d5(a_d[5]), .fft_d6(a_d[6]), .fft_d7(a_d[7]),
    .fft_d8(a_d[8]), .fft_d9(a_d[9]), .fft_d10(a_d[10]), .fft_d11(a_d[11]),
    .fft_d12(a_d[12]), .fft_d13(a_d[13]), .fft_d14(a_d[14]), .fft_d15(a_d[15]),
    .fft_valid(a_valid), .frame_err(a_err), .frame_cnt(a_cnt)
  );

  fft_frame_pack #(.DATA_W(32), .BIT_REV(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .fft_d0(b_d[0]), .fft_d1(b_d[1]), .fft_d2(b_d[2]), .fft_d3(b_d[3]),
    .fft_d4(b_d[4]), .fft_d5(b_d[5]), .fft_d6(b_d[6]), .fft_d7(b_d[7]),
    .fft_d8(b_d[8]), .fft_d9(b_d[9]), .fft_d10(b_d[10]), .fft_d11(b_d[11]),
    .fft_d12(b_d[12]), .fft_d13(b_d[13]), .fft_d14(b_d[14]), .fft_d15(b_d[15]),
    .fft_valid(b_valid), .frame_err(b_err), .frame_cnt(b_cnt)
  );

  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int k = 0; k < 16; k++) begin
      a_flat[k*32 +: 32] = a_d[k];
      b_flat[k*32 +: 32] = b_d[k];
    end
  end

  function automatic int rev4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  task automatic mon_dut(input int w, input frame_t cur, input logic v, input logic e,
                         input logic [15:0] cnt);
    frame_t      exp_f;
    logic [15:0] exp_c;
    bit          empty;
    if (e) err_seen[w]++;
    if (!rst_edge && !v) begin
      checks++;
      if (cur !== prev[w]) begin
        errors++;
        $display("FAIL hold_%0d: outputs changed without fft_valid, got %h want %h",
                 w, cur, prev[w]);
      end
    end
    if (v) begin
      checks++;
      if (vlast[w]) begin
        errors++;
        $display("FAIL pulse_%0d: fft_valid high on two adjacent cycles, got 1 want 0", w);
      end
      empty = (w == 0) ? (a_q.size() == 0) : (b_q.size() == 0);
      checks++;
      if (empty) begin
        errors++;
        $display("FAIL unexpected_valid_%0d: got fft_valid=1, want no frame", w);
      end else begin
        if (w == 0) begin
          exp_f = a_q.pop_front();
          exp_c = a_cnt_q.pop_front();
        end else begin
          exp_f = b_q.pop_front();
          exp_c = b_cnt_q.pop_front();
        end
        for (int k = 0; k < 16; k++) begin
          checks++;
          if (cur[k*32 +: 32] !== exp_f[k*32 +: 32]) begin
            errors++;
            $display("FAIL frame_%0d_slot%0d: got %h, want %h", w, k, cur[k*32 +: 32],
                     exp_f[k*32 +: 32]);
          end
        end
        checks++;
        if (cnt !== exp_c) begin
          errors++;
          $display("FAIL frame_cnt_%0d: got %0d, want %0d", w, cnt, exp_c);
        end
      end
      vprev[w] = vcyc[w];
      vcyc[w]  = cyc;
    end
    vlast[w] = v;
    prev[w]  = cur;
  endtask

  always @(negedge clk) begin
    mon_dut(0, a_flat, a_valid, a_err, a_cnt);
    mon_dut(1, b_flat, b_valid, b_err, b_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sop, input logic [31:0] d);
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 32'h0;
  endtask

  // Bin k carries hi|k. A expects it in slot k, B in slot rev4(k).
  task automatic push_exp(input logic [31:0] hi);
    frame_t fa, fb;
    fa = '0;
    fb = '0;
    for (int k = 0; k < 16; k++) begin
      fa[k*32 +: 32]       = hi | 32'(k);
      fb[rev4(k)*32 +: 32] = hi | 32'(k);
    end
    exp_cnt = exp_cnt + 16'd1;
    a_q.push_back(fa);
    b_q.push_back(fb);
    a_cnt_q.push_back(exp_cnt);
    b_cnt_q.push_back(exp_cnt);
  endtask

  task automatic send_frame(input logic [31:0] hi, input int max_gap);
    push_exp(hi);
    for (int k = 0; k < 16; k++) begin
      beat(k == 0, hi | 32'(k));
      if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_a_d%0d", tag, k), a_d[k], 32'h0);
      chk($sformatf("%s_b_d%0d", tag, k), b_d[k], 32'h0);
    end
    chk({tag, "_valid"}, {30'h0, a_valid, b_valid}, 32'h0);
    chk({tag, "_err"}, {30'h0, a_err, b_err}, 32'h0);
    chk({tag, "_cnt_a"}, {16'h0, a_cnt}, 32'h0);
    chk({tag, "_cnt_b"}, {16'h0, b_cnt}, 32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 32'h0;
    idle(2);
    chk_zero("reset");
    rst = 1'b0;
    idle(1);

    // Orphan beat in IDLE.
    beat(1'b0, 32'hDEAD_BEEF);
    idle(2);
    chk("orphan_err_a", err_seen[0], 1);
    chk("orphan_err_b", err_seen[1], 1);
    chk_zero("orphan");

    // In-order data 0x100+k.
    send_frame(32'h0000_0100, 0);
    chk("inorder_a_d0", a_d[0], 32'h100);
    chk("inorder_a_d15", a_d[15], 32'h10F);
    chk("inorder_b_d1", b_d[1], 32'h108);
    idle(2);

    // Data = serial index; bit-reversed slots hand-computed.
    send_frame(32'h0, 0);
    chk("rev_b_d1", b_d[1], 32'd8);
    chk("rev_b_d2", b_d[2], 32'd4);
    chk("rev_b_d3", b_d[3], 32'd12);
    chk("rev_b_d8", b_d[8], 32'd1);
    chk("rev_b_d15", b_d[15], 32'd15);
    chk("rev_a_d1", a_d[1], 32'd1);
    idle(3);

    // Random gaps, then two frames back-to-back.
    send_frame(32'h1111_0000, 3);
    send_frame(32'h2222_0000, 0);
    send_frame(32'h3333_0000, 0);
    idle(2);
    chk("b2b_spacing_a", vcyc[0] - vprev[0], 16);
    chk("b2b_spacing_b", vcyc[1] - vprev[1], 16);
    chk("b2b_cnt_a", {16'h0, a_cnt}, 32'd5);

    // Early sop: partial AAAA frame abandoned, BBBB frame completes.
    for (int k = 0; k < 6; k++) beat(k == 0, 32'hAAAA_0000 | 32'(k));
    send_frame(32'hBBBB_0000, 0);
    idle(2);
    chk("early_err_a", err_seen[0], 2);
    chk("early_err_b", err_seen[1], 2);
    chk("early_hi_a_d5", a_d[5] & 32'hFFFF_0000, 32'hBBBB_0000);

    // Reset mid-frame.
    for (int k = 0; k < 10; k++) beat(k == 0, 32'hCCCC_0000 | 32'(k));
    rst = 1'b1;
    idle(1);
    chk_zero("midrst");
    rst     = 1'b0;
    exp_cnt = 16'd0;
    send_frame(32'hDDDD_0000, 0);
    idle(3);
    chk("midrst_cnt_a", {16'h0, a_cnt}, 32'd1);
    chk("midrst_cnt_b", {16'h0, b_cnt}, 32'd1);
    chk("midrst_err_a", err_seen[0], 2);
    chk("midrst_err_b", err_seen[1], 2);

    chk("pending_a", a_q.size(), 0);
    chk("pending_b", b_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
